// File: rtl/ddr3_wr_control_if.sv
// Write-FIFO and MIG app/WDF handshake signals used by ddr3_wr_control.
// master = the write controller, slave = the FIFO/MIG side.
interface ddr3_wr_control_if #(
    parameter int unsigned ADDR_W = 23
);
    logic              ddr3_wr_fifo_empty;
    logic              ddr3_wr_fifo_tlast;
    logic              ddr3_wr_fifo_rd_en;
    logic              app_wdf_rdy;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_rdy;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W+2:0] ddr3_wr_addr;

    modport master (
        input  ddr3_wr_fifo_empty,
        input  ddr3_wr_fifo_tlast,
        input  app_wdf_rdy,
        input  app_rdy,
        output ddr3_wr_fifo_rd_en,
        output app_wdf_wren,
        output app_wdf_end,
        output app_en,
        output app_cmd,
        output ddr3_wr_addr
    );

    modport slave (
        output ddr3_wr_fifo_empty,
        output ddr3_wr_fifo_tlast,
        output app_wdf_rdy,
        output app_rdy,
        input  ddr3_wr_fifo_rd_en,
        input  app_wdf_wren,
        input  app_wdf_end,
        input  app_en,
        input  app_cmd,
        input  ddr3_wr_addr
    );
endinterface

// File: rtl/ddr3_wr_control.sv
// Drains one fill of 128-bit bursts from the write FIFO into the MIG: WDF beats go first,
// the matching write commands follow, with at most MAX_AHEAD beats outstanding.
module ddr3_wr_control #(
    parameter int unsigned MAX_AHEAD = 8,
    parameter int unsigned ADDR_W    = 23,
    parameter int unsigned CNT_W     = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              acq_enabled,
    input  logic              enable_writing,
    input  logic [ADDR_W-1:0] ddr3_wr_start_addr,
    input  logic [CNT_W-1:0]  ddr3_wr_burst_cnt,
    output logic              writing_done,
    output logic              wr_error,
    ddr3_wr_control_if.master bus
);

    localparam logic [2:0] StIdle  = 3'b001;
    localparam logic [2:0] StWrite = 3'b010;
    localparam logic [2:0] StDone  = 3'b100;

    localparam logic [3:0] AheadMax = 4'(MAX_AHEAD);

    (* ASYNC_REG = "TRUE" *) logic sync1_q;
    (* ASYNC_REG = "TRUE" *) logic sync2_q;
    (* ASYNC_REG = "TRUE" *) logic sync3_q;

    logic              start_pulse_d, start_pulse_q;
    logic [2:0]        state_d, state_q;
    logic [ADDR_W-1:0] address_gen_d, address_gen_q;
    logic [CNT_W-1:0]  addr_cntr_d, addr_cntr_q;
    logic [CNT_W-1:0]  data_cntr_d, data_cntr_q;
    logic [3:0]        ahead_cnt_d, ahead_cnt_q;
    logic              wr_error_d, wr_error_q;

    logic in_write;
    logic wdf_go;
    logic cmd_valid;
    logic cmd_accept;
    logic tlast_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= enable_writing;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign start_pulse_d = sync2_q & ~sync3_q;

    assign in_write   = (state_q == StWrite);
    assign wdf_go     = in_write & acq_enabled & ~bus.ddr3_wr_fifo_empty & bus.app_wdf_rdy &
                        (data_cntr_q != '0) & (ahead_cnt_q < AheadMax);
    // A command is only issued once its data beat is already in the WDF.
    assign cmd_valid  = in_write & (addr_cntr_q != '0) & (ahead_cnt_q != 4'd0);
    assign cmd_accept = cmd_valid & bus.app_rdy;
    assign tlast_bad  = bus.ddr3_wr_fifo_tlast ^ (data_cntr_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        if (!sync2_q) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (start_pulse_q) state_d = StWrite;
                StWrite: if ((data_cntr_q == '0) && (addr_cntr_q == '0)) state_d = StDone;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        address_gen_d = address_gen_q;
        addr_cntr_d   = addr_cntr_q;
        data_cntr_d   = data_cntr_q;
        ahead_cnt_d   = ahead_cnt_q;
        wr_error_d    = wr_error_q;
        if (start_pulse_q) begin
            address_gen_d = ddr3_wr_start_addr;
            addr_cntr_d   = ddr3_wr_burst_cnt;
            data_cntr_d   = ddr3_wr_burst_cnt;
            ahead_cnt_d   = 4'd0;
            wr_error_d    = 1'b0;
        end else begin
            if (wdf_go) begin
                data_cntr_d = data_cntr_q - CNT_W'(1);
                if (tlast_bad) wr_error_d = 1'b1;
            end
            if (cmd_accept) begin
                address_gen_d = address_gen_q + ADDR_W'(1);
                addr_cntr_d   = addr_cntr_q - CNT_W'(1);
            end
            case ({wdf_go, cmd_accept})
                2'b10:   ahead_cnt_d = ahead_cnt_q + 4'd1;
                2'b01:   ahead_cnt_d = ahead_cnt_q - 4'd1;
                default: ahead_cnt_d = ahead_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_pulse_q <= 1'b0;
            state_q       <= StIdle;
            address_gen_q <= '0;
            addr_cntr_q   <= '0;
            data_cntr_q   <= '0;
            ahead_cnt_q   <= 4'd0;
            wr_error_q    <= 1'b0;
        end else begin
            start_pulse_q <= start_pulse_d;
            state_q       <= state_d;
            address_gen_q <= address_gen_d;
            addr_cntr_q   <= addr_cntr_d;
            data_cntr_q   <= data_cntr_d;
            ahead_cnt_q   <= ahead_cnt_d;
            wr_error_q    <= wr_error_d;
        end
    end

    assign bus.app_wdf_wren       = wdf_go;
    assign bus.app_wdf_end        = wdf_go;
    assign bus.ddr3_wr_fifo_rd_en = wdf_go;
    assign bus.app_en             = cmd_valid;
    assign bus.app_cmd            = 3'b000;
    assign bus.ddr3_wr_addr       = {address_gen_q, 3'b000};

    assign writing_done = (state_q == StDone);
    assign wr_error     = wr_error_q;

endmodule

// File: tb/tb_ddr3_wr_control.sv
// Bench for ddr3_wr_control: directed fills, a FIFO model, and a scoreboard monitor that
// checks every WDF beat and every accepted command address as the DUT presents them.
module tb_ddr3_wr_control;
    localparam int unsigned MAX_AHEAD = 8;
    localparam int unsigned ADDR_W    = 23;
    localparam int unsigned CNT_W     = 24;

    logic              clk;
    logic              reset_n;
    logic              acq_enabled;
    logic              enable_writing;
    logic [ADDR_W-1:0] start_addr;
    logic [CNT_W-1:0]  burst_cnt;
    logic              writing_done;
    logic              wr_error;

    ddr3_wr_control_if #(.ADDR_W(ADDR_W)) bus ();

    ddr3_wr_control #(
        .MAX_AHEAD(MAX_AHEAD),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .acq_enabled       (acq_enabled),
        .enable_writing    (enable_writing),
        .ddr3_wr_start_addr(start_addr),
        .ddr3_wr_burst_cnt (burst_cnt),
        .writing_done      (writing_done),
        .wr_error          (wr_error),
        .bus               (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int beats_seen;
    int cmds_seen;
    int ahead_model;
    bit fifo_q[$];
    logic [31:0] exp_addr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic refresh_fifo();
        bus.ddr3_wr_fifo_empty = (fifo_q.size() == 0);
        bus.ddr3_wr_fifo_tlast = (fifo_q.size() != 0) ? fifo_q[0] : 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples on the falling edge, pops the FIFO model after the next rise.
    initial begin
        bit pop_now;
        logic [31:0] exp_a;
        forever begin
            @(negedge clk);
            pop_now = 1'b0;
            if (reset_n) begin
                if (bus.app_en) begin
                    check("app_en_has_data", 32'(ahead_model > 0), 32'd1);
                    check("app_cmd", 32'(bus.app_cmd), 32'd0);
                end
                if (bus.app_wdf_wren || bus.ddr3_wr_fifo_rd_en) begin
                    check("wdf_strobes", 32'({bus.app_wdf_wren, bus.app_wdf_end,
                                              bus.ddr3_wr_fifo_rd_en}), 32'd7);
                    check("wren_fifo_nonempty", 32'(fifo_q.size() != 0), 32'd1);
                    pop_now = 1'b1;
                    beats_seen++;
                    ahead_model++;
                end
                if (bus.app_en && bus.app_rdy) begin
                    if (exp_addr_q.size() == 0) begin
                        check("unexpected_cmd", 32'(bus.ddr3_wr_addr), 32'hFFFF_FFFF);
                    end else begin
                        exp_a = exp_addr_q.pop_front();
                        check("cmd_addr", 32'(bus.ddr3_wr_addr), exp_a);
                    end
                    cmds_seen++;
                    ahead_model--;
                end
                if (pop_now) check("ahead_bound", 32'(ahead_model <= MAX_AHEAD), 32'd1);
            end
            @(posedge clk);
            #1;
            if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
            refresh_fifo();
        end
    end

    task automatic load_fifo(input int n, input int tlast_pos);
        for (int i = 1; i <= n; i++) fifo_q.push_back(i == tlast_pos);
        refresh_fifo();
    endtask

    task automatic go(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
        start_addr     = a;
        burst_cnt      = n;
        ahead_model    = 0;
        beats_seen     = 0;
        cmds_seen      = 0;
        enable_writing = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int k = 0; k < budget && !writing_done; k++) tick();
        check(name, 32'(writing_done), 32'd1);
    endtask

    task automatic end_fill();
        enable_writing = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        reset_n            = 1'b0;
        acq_enabled        = 1'b1;
        enable_writing     = 1'b0;
        start_addr         = '0;
        burst_cnt          = '0;
        bus.app_wdf_rdy    = 1'b1;
        bus.app_rdy        = 1'b1;
        beats_seen         = 0;
        cmds_seen          = 0;
        ahead_model        = 0;
        refresh_fifo();
        #23;
        check("rst_outputs", 32'({bus.app_wdf_wren, bus.app_wdf_end, bus.ddr3_wr_fifo_rd_en,
                                  bus.app_en, writing_done, wr_error}), 32'd0);
        check("rst_addr", 32'(bus.ddr3_wr_addr), 32'd0);
        check("rst_cmd", 32'(bus.app_cmd), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();

        // Basic 4-burst fill
        load_fifo(4, 4);
        exp_addr_q.push_back(32'h80);
        exp_addr_q.push_back(32'h88);
        exp_addr_q.push_back(32'h90);
        exp_addr_q.push_back(32'h98);
        go(23'h10, 24'd4);
        wait_done("t1_done", 100);
        check("t1_beats", 32'(beats_seen), 32'd4);
        check("t1_cmds", 32'(cmds_seen), 32'd4);
        check("t1_wr_error", 32'(wr_error), 32'd0);
        check("t1_exp_left", 32'(exp_addr_q.size()), 32'd0);
        end_fill();

        // Command side stalled: data may run at most MAX_AHEAD beats ahead
        bus.app_rdy = 1'b0;
        load_fifo(10, 10);
        for (int i = 0; i < 10; i++) exp_addr_q.push_back(32'h80 + 32'(8 * i));
        go(23'h10, 24'd10);
        repeat (20) tick();
        check("t2_ahead_sat", 32'(beats_seen), 32'd8);
        check("t2_rd_en_stall", 32'(bus.ddr3_wr_fifo_rd_en), 32'd0);
        check("t2_no_cmds", 32'(cmds_seen), 32'd0);
        bus.app_rdy = 1'b1;
        wait_done("t2_done", 100);
        check("t2_beats", 32'(beats_seen), 32'd10);
        check("t2_cmds", 32'(cmds_seen), 32'd10);
        end_fill();

        // Zero-length fill: DONE two cycles after the registered start pulse
        go(23'h0, 24'd0);
        repeat (4) tick();
        check("t3_done_early", 32'(writing_done), 32'd0);
        tick();
        check("t3_done", 32'(writing_done), 32'd1);
        check("t3_traffic", 32'(beats_seen + cmds_seen), 32'd0);
        end_fill();

        // Early tlast flags an error but the full count is still written
        load_fifo(3, 2);
        exp_addr_q.push_back(32'h100);
        exp_addr_q.push_back(32'h108);
        exp_addr_q.push_back(32'h110);
        go(23'h20, 24'd3);
        wait_done("t4_done", 100);
        check("t4_wr_error", 32'(wr_error), 32'd1);
        check("t4_beats", 32'(beats_seen), 32'd3);
        check("t4_cmds", 32'(cmds_seen), 32'd3);
        end_fill();

        // Mid-fill abort, then restart from a new address
        load_fifo(6, 6);
        for (int i = 0; i < 6; i++) exp_addr_q.push_back(32'h800 + 32'(8 * i));
        go(23'h100, 24'd6);
        for (int k = 0; k < 50 && cmds_seen < 2; k++) tick();
        check("t5_two_cmds", 32'(cmds_seen >= 2), 32'd1);
        check("t5_err_cleared", 32'(wr_error), 32'd0);
        enable_writing = 1'b0;
        repeat (3) tick();
        check("t5_abort_quiet", 32'({bus.app_wdf_wren, bus.app_en}), 32'd0);
        repeat (4) tick();
        exp_addr_q.delete();
        fifo_q.delete();
        refresh_fifo();
        load_fifo(2, 2);
        exp_addr_q.push_back(32'h1000);
        exp_addr_q.push_back(32'h1008);
        go(23'h200, 24'd2);
        wait_done("t5_done", 100);
        check("t5_cmds", 32'(cmds_seen), 32'd2);
        check("t5_beats", 32'(beats_seen), 32'd2);
        end_fill();

        // Address wrap at the top of the burst-address space
        load_fifo(2, 2);
        exp_addr_q.push_back(32'h3FF_FFF8);
        exp_addr_q.push_back(32'h000_0000);
        go(23'h7FFFFF, 24'd2);
        wait_done("t6_done", 100);
        check("t6_cmds", 32'(cmds_seen), 32'd2);
        check("t6_wr_error", 32'(wr_error), 32'd0);
        end_fill();

        // Asynchronous reset in the middle of a fill
        load_fifo(4, 4);
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'h200 + 32'(8 * i));
        go(23'h40, 24'd4);
        for (int k = 0; k < 50 && beats_seen < 1; k++) tick();
        check("t7_started", 32'(beats_seen >= 1), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_rst_outputs", 32'({bus.app_wdf_wren, bus.app_wdf_end, bus.ddr3_wr_fifo_rd_en,
                                     bus.app_en, writing_done, wr_error}), 32'd0);
        check("t7_rst_addr", 32'(bus.ddr3_wr_addr), 32'd0);
        enable_writing = 1'b0;
        repeat (2) tick();
        exp_addr_q.delete();
        fifo_q.delete();
        refresh_fifo();
        reset_n = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
